// File: rtl/cam_capture_ctrl.sv
// cam_capture_ctrl: camera frame capture sequencer packing 8-bit pixels into a 32-bit valid/ready stream.
module cam_capture_ctrl #(
    parameter int CNT_W = 12,
    parameter int FRM_W = 8
) (
    input  logic             pclk,
    input  logic             resetn,
    input  logic             cam_hsync,
    input  logic             cam_vsync,
    input  logic [7:0]       cam_pixels,
    input  logic             cfg_start,
    input  logic             cfg_stop,
    input  logic [FRM_W-1:0] cfg_frames,
    input  logic [CNT_W-1:0] cfg_cols,
    input  logic [CNT_W-1:0] cfg_rows,
    input  logic             cfg_phase,
    input  logic             err_clr,
    output logic [31:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sof,
    output logic             out_eol,
    output logic             busy,
    output logic             frame_done,
    output logic [FRM_W-1:0] frames_captured,
    output logic             err_overflow,
    output logic             err_geom
);
    typedef enum logic [2:0] {IDLE, WAIT_LOW, WAIT_SOF, ACTIVE, FRAME_END} state_t;
    state_t state, state_nx;
    logic hs_q, hs_d, vs_q, vs_d, tog, sof_pend, stop_pend;
    logic [7:0] px_q;
    logic [CNT_W-1:0] col, rows;
    logic [31:0] pack;
    always_ff @(posedge pclk) begin
        if (!resetn) begin
            {hs_q, hs_d, vs_q, vs_d} <= '0;
            px_q <= '0;
        end else begin
            hs_q <= cam_hsync;
            hs_d <= hs_q;
            vs_q <= cam_vsync;
            vs_d <= vs_q;
            px_q <= cam_pixels;
        end
    end
    logic hs_rise, hs_fall, vs_rise, vs_fall, act, frm_last;
    assign hs_rise  = hs_q & ~hs_d;
    assign hs_fall  = ~hs_q & hs_d;
    assign vs_rise  = vs_q & ~vs_d;
    assign vs_fall  = ~vs_q & vs_d;
    assign act      = state == ACTIVE;
    assign frm_last = stop_pend || (cfg_frames != '0 && frames_captured + FRM_W'(1) == cfg_frames);
    always_ff @(posedge pclk) begin
        if (!resetn) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = cfg_start ? WAIT_LOW : IDLE;
            WAIT_LOW:  state_nx = cfg_stop ? IDLE : !vs_q ? WAIT_SOF : WAIT_LOW;
            WAIT_SOF:  state_nx = cfg_stop ? IDLE : vs_rise ? ACTIVE : WAIT_SOF;
            ACTIVE:    state_nx = vs_fall ? FRAME_END : ACTIVE;
            FRAME_END: state_nx = frm_last ? IDLE : WAIT_SOF;
            default:   state_nx = IDLE;
        endcase
    end
    always_comb begin
        busy       = state != IDLE;
        frame_done = state == FRAME_END;
    end
    // The hsync-rise cycle is slot 0 of column 0, so counters restart combinationally.
    logic tog_e, sample, word_done, flush, eol_tag, load, keep;
    logic [CNT_W-1:0] col_e, col_nx;
    logic [31:0] pack_w, load_data;
    assign tog_e     = hs_rise ? 1'b0 : tog;
    assign col_e     = hs_rise ? '0 : col;
    assign col_nx    = col_e + CNT_W'(1);
    assign sample    = act && hs_q && tog_e == cfg_phase && col_e < cfg_cols;
    assign word_done = sample && col_e[1:0] == 2'd3;
    assign flush     = act && hs_fall && col[1:0] != 2'd0;
    assign eol_tag   = act && hs_fall && col[1:0] == 2'd0 && col != '0;
    assign load      = word_done || flush;
    assign keep      = out_valid && !out_ready;
    assign load_data = flush ? pack : pack_w;
    always_comb begin
        pack_w = pack;
        pack_w[8*col_e[1:0] +: 8] = px_q;
    end
    always_ff @(posedge pclk) begin
        if (!resetn) begin
            {tog, sof_pend, stop_pend, out_valid, out_sof, out_eol, err_overflow, err_geom} <= '0;
            {col, rows, pack, out_data, frames_captured} <= '0;
        end else begin
            if (act && hs_q) begin
                tog <= ~tog_e;
                col <= sample ? col_nx : col_e;
            end
            if (load || state == WAIT_SOF) pack <= '0;
            else if (sample) pack <= pack_w;
            if (state == WAIT_SOF && vs_rise) rows <= '0;
            else if (act && hs_rise && !(&rows)) rows <= rows + CNT_W'(1);
            if (state == WAIT_SOF && vs_rise) sof_pend <= 1'b1;
            else if (load) sof_pend <= 1'b0;
            stop_pend <= act && (stop_pend || cfg_stop);
            if (state == IDLE && cfg_start) frames_captured <= '0;
            else if (frame_done) frames_captured <= frames_captured + FRM_W'(1);
            if (load && !keep) begin
                out_data  <= load_data;
                out_valid <= 1'b1;
                out_sof   <= sof_pend;
                out_eol   <= flush || col_nx == cfg_cols;
            end else if (out_valid && out_ready) begin
                {out_valid, out_sof, out_eol} <= '0;
            end else if (eol_tag && keep) begin
                out_eol <= 1'b1;
            end
            err_overflow <= (load && keep) || (err_overflow && !err_clr);
            err_geom     <= (act && hs_fall && col != cfg_cols) || (frame_done && rows != cfg_rows)
                            || (err_geom && !err_clr);
        end
    end
endmodule

// File: tb/tb_cam_capture_ctrl.sv
// tb_cam_capture_ctrl: directed checks of capture, packing, handshake, geometry, stop and reset.
module tb_cam_capture_ctrl;
    logic pclk = 0, resetn = 0, cam_hsync = 0, cam_vsync = 0, cfg_start = 0, cfg_stop = 0;
    logic cfg_phase = 0, err_clr = 0, out_ready = 1;
    logic [7:0] cam_pixels = 0, cfg_frames = 0;
    logic [11:0] cfg_cols = 0, cfg_rows = 0;
    logic [31:0] out_data;
    logic out_valid, out_sof, out_eol, busy, frame_done, err_overflow, err_geom;
    logic [7:0] frames_captured;
    int checks = 0, failures = 0, nw = 0, fd = 0;
    bit mon_clr = 0, drv_done = 0;
    logic [31:0] wd [0:255];
    bit ws [0:255];
    bit we [0:255];

    cam_capture_ctrl dut (
        .pclk(pclk), .resetn(resetn), .cam_hsync(cam_hsync), .cam_vsync(cam_vsync),
        .cam_pixels(cam_pixels), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
        .cfg_frames(cfg_frames), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
        .cfg_phase(cfg_phase), .err_clr(err_clr), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof), .out_eol(out_eol),
        .busy(busy), .frame_done(frame_done), .frames_captured(frames_captured),
        .err_overflow(err_overflow), .err_geom(err_geom)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) begin
        if (mon_clr) begin
            nw = 0;
            fd = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (nw < 256) begin
                    wd[nw] = out_data;
                    ws[nw] = out_sof;
                    we[nw] = out_eol;
                end
                nw++;
            end
            if (frame_done) fd++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge pclk);
        #1;
    endtask

    task automatic clr_mon;
        mon_clr = 1;
        tick;
        mon_clr = 0;
    endtask

    task automatic go(input int frames, input int cols, input int rows, input bit phase);
        cfg_frames = 8'(frames);
        cfg_cols   = 12'(cols);
        cfg_rows   = 12'(rows);
        cfg_phase  = phase;
        cfg_start  = 1;
        tick;
        cfg_start  = 0;
        tick;
    endtask

    task automatic pulse_clr;
        err_clr = 1;
        tick;
        err_clr = 0;
        tick;
    endtask

    // mode 0 holds each pixel for a 2-clock slot; mode 1 changes the pixel every clock
    task automatic line(input int r, input int n, input int m);
        cam_hsync = 1;
        for (int k = 0; k < 2 * n; k++) begin
            cam_pixels = 8'((m != 0 ? k : k / 2) + r);
            tick;
        end
        cam_hsync  = 0;
        cam_pixels = 0;
        repeat (6) tick;
    endtask

    task automatic frame(input int nrows, input int n, input int m, input int stop_row);
        cam_vsync = 1;
        repeat (4) tick;
        for (int r = 0; r < nrows; r++) begin
            if (r == stop_row) begin
                cfg_stop = 1;
                tick;
                cfg_stop = 0;
            end
            line(r, n, m);
        end
        cam_vsync = 0;
        repeat (8) tick;
    endtask

    function automatic logic [31:0] exp_word(input int r, input int w, input int lim);
        logic [31:0] v = '0;
        for (int i = 0; i < 4; i++)
            if (4 * w + i < lim) v[8*i +: 8] = 8'(4 * w + i + r);
        return v;
    endfunction

    task automatic check_frame(input string tag, input int nrows, input int n, input int cfgc);
        int lim = n < cfgc ? n : cfgc;
        int wpl = (lim + 3) / 4;
        int bad = 0;
        chk({tag, "_words"}, nw, nrows * wpl);
        for (int i = 0; i < nw && i < 256; i++)
            if (wd[i] !== exp_word(i / wpl, i % wpl, lim) || ws[i] != (i == 0) || we[i] != (i % wpl == wpl - 1))
                bad++;
        chk({tag, "_bad_words"}, bad, 0);
    endtask

    initial begin
        logic [31:0] held;
        bit seen;
        int bad, nw_r;
        repeat (3) tick;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frames", frames_captured, 0);
        chk("rst_errs", {err_overflow, err_geom}, 0);
        resetn = 1;
        tick;

        clr_mon;
        go(1, 64, 8, 0);
        chk("t1_busy_start", busy, 1);
        frame(8, 64, 0, -1);
        check_frame("t1", 8, 64, 64);
        chk("t1_word0", wd[0], 32'h03020100);
        chk("t1_sof0", ws[0], 1);
        chk("t1_eol15", we[15], 1);
        chk("t1_done", fd, 1);
        chk("t1_frames", frames_captured, 1);
        chk("t1_busy_end", busy, 0);
        chk("t1_errs", {err_overflow, err_geom}, 0);

        clr_mon;
        cam_vsync = 1;
        repeat (3) tick;
        go(1, 64, 8, 0);
        for (int r = 0; r < 3; r++) line(r, 64, 0);
        cam_vsync = 0;
        repeat (6) tick;
        chk("t2_no_words_midframe", nw, 0);
        frame(8, 64, 0, -1);
        check_frame("t2", 8, 64, 64);
        chk("t2_done", fd, 1);

        clr_mon;
        go(1, 64, 8, 0);
        seen = 0;
        bad  = 0;
        held = '0;
        fork
            frame(8, 64, 0, -1);
            begin
                for (int t = 0; t < 3000 && !seen; t++)
                    if (out_valid && nw == 5) seen = 1;
                    else tick;
                if (seen) begin
                    out_ready = 0;
                    held = out_data;
                    repeat (10) begin
                        tick;
                        if (out_data !== held || !out_valid) bad++;
                    end
                    out_ready = 1;
                end
            end
        join
        chk("t3_word5_seen", seen, 1);
        chk("t3_word5", held, 32'h17161514);
        chk("t3_held_stable", bad, 0);
        chk("t3_overflow", err_overflow, 1);
        chk("t3_words", nw, 127);
        pulse_clr;
        chk("t3_overflow_clr", err_overflow, 0);

        clr_mon;
        go(1, 64, 8, 0);
        drv_done = 0;
        fork
            begin
                frame(8, 64, 0, -1);
                drv_done = 1;
            end
            begin
                while (!drv_done) begin
                    out_ready = ~out_ready;
                    tick;
                end
                out_ready = 1;
            end
        join
        check_frame("t4", 8, 64, 64);
        chk("t4_overflow", err_overflow, 0);

        clr_mon;
        go(1, 64, 8, 0);
        frame(8, 62, 0, -1);
        check_frame("t5", 8, 62, 64);
        chk("t5_partial", wd[15], 32'h00003d3c);
        chk("t5_partial_eol", we[15], 1);
        chk("t5_geom", err_geom, 1);
        pulse_clr;
        chk("t5_geom_clr", err_geom, 0);

        clr_mon;
        go(0, 64, 8, 0);
        frame(8, 64, 0, -1);
        frame(8, 64, 0, -1);
        chk("t6_busy_cont", busy, 1);
        chk("t6_frames2", frames_captured, 2);
        frame(8, 64, 0, 4);
        chk("t6_frames", frames_captured, 3);
        chk("t6_done", fd, 3);
        chk("t6_words", nw, 384);
        chk("t6_busy_end", busy, 0);
        clr_mon;
        frame(8, 64, 0, -1);
        chk("t6_idle_words", nw, 0);
        chk("t6_idle_done", fd, 0);

        clr_mon;
        go(1, 64, 8, 1);
        cam_vsync = 1;
        repeat (4) tick;
        for (int r = 0; r < 3; r++) line(r, 64, 1);
        cam_hsync = 1;
        for (int k = 0; k < 20; k++) begin
            cam_pixels = 8'(k + 3);
            tick;
        end
        chk("t7_phase_word0", wd[0], 32'h07050301);
        chk("t7_phase_sof", ws[0], 1);
        chk("t7_phase_line1", wd[16], 32'h08060402);
        resetn = 0;
        tick;
        chk("t7_rst_valid", out_valid, 0);
        chk("t7_rst_data", out_data, 0);
        chk("t7_rst_flags", {out_sof, out_eol, busy, err_overflow, err_geom}, 0);
        nw_r = nw;
        resetn = 1;
        repeat (20) tick;
        cam_hsync = 0;
        repeat (6) tick;
        for (int r = 4; r < 8; r++) line(r, 64, 1);
        cam_vsync = 0;
        repeat (8) tick;
        frame(8, 64, 1, -1);
        chk("t7_no_words_after_rst", nw, nw_r);
        chk("t7_busy", busy, 0);
        chk("t7_frames", frames_captured, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
